wb_stage: RTL

- Writeback stage of the 64-bit RV64 core. Sits directly upstream of the register file and drives its single write port (WE3/A3/WD3).
- Merges two result sources:
  - The in-order MEM pipeline: ALU result, PC+4, or a load, with load byte/half/word extraction and sign/zero extension.
  - The long-latency mul/div unit, through a 2-entry buffer.
- Pipeline results have priority. Buffered results drain in idle slots, or by forcing a pipeline stall after a starvation limit.

---
 rtl/wb_pkg.sv | 43 ++++
 rtl/wb_load_ext.sv | 40 ++++
 rtl/wb_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared encodings for the writeback stage: write-data source
//            select, load funct3 codes, default data width and a helper
//            that flags misaligned loads.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_XLEN = 64;

  // Write-data source select
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_NONE = 2'd3;

  // Load funct3 encodings
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_D  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  localparam logic [2:0] LD_WU = 3'b110;

  // True when the access width does not divide the byte offset
  function automatic logic ld_misaligned(input logic [2:0] funct3,
                                         input logic [2:0] addr_lo);
    logic r;
    r = 1'b0;
    case (funct3)
      LD_H, LD_HU: r = addr_lo[0];
      LD_W, LD_WU: r = |addr_lo[1:0];
      LD_D:        r = |addr_lo;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_ext
// Purpose  : Combinational load extraction: shifts the aligned doubleword
//            down by the byte offset, then sign/zero extends the selected
//            width. Reserved funct3 yields zero.
// Revision : 1.0 - initial release
// ============================================================================
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = raw_i >> {addr_lo_i, 3'b000};

  // Select width and extension mode from funct3
  always_comb begin
    data_o = '0;
    case (funct3_i)
      LD_B:    data_o = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      LD_H:    data_o = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      LD_W:    data_o = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      LD_D:    data_o = w_shifted;
      LD_BU:   data_o = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      LD_HU:   data_o = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      LD_WU:   data_o = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : RV64 writeback stage. Drives the register-file write port from
//            either the in-order MEM pipeline (priority) or a 2-entry buffer
//            of mul/div results. A buffered result that waits STARVE_MAX
//            cycles forces a one-cycle pipeline stall to drain.
// Options  : WB_LOAD_MISALIGN_EN - adds ld_misalign_o and suppresses writes
//            of misaligned loads.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN       = WB_XLEN,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_valid_i,
  input  logic [4:0]      mem_rd_i,
  input  logic [1:0]      mem_wb_sel_i,
  input  logic [XLEN-1:0] mem_alu_res_i,
  input  logic [XLEN-1:0] mem_pc4_i,
  input  logic [XLEN-1:0] mem_ld_data_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [2:0]      mem_addr_lo_i,
  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [4:0]      md_rd_i,
  input  logic [XLEN-1:0] md_result_i,
  output logic            stall_o,
`ifdef WB_LOAD_MISALIGN_EN
  output logic            ld_misalign_o,
`endif
  output logic            we_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] wd_o
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  logic [XLEN-1:0] w_ld_val;
  logic [XLEN-1:0] w_pipe_wd;
  logic            w_mem_wr;
  logic            w_pw;
  logic            w_push;
  logic            w_pop;

  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wd;
  logic [4:0]      r_buf_rd   [2];
  logic [XLEN-1:0] r_buf_data [2];
  logic            r_head;
  logic            r_tail;
  logic [1:0]      r_count;
  logic [3:0]      r_starve;
  logic            r_ready_en;

  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3_i  (mem_funct3_i),
    .addr_lo_i (mem_addr_lo_i),
    .raw_i     (mem_ld_data_i),
    .data_o    (w_ld_val)
  );

  // Forced drain depends only on registered state
  assign stall_o    = (r_count != 2'd0) && (r_starve == c_starve_max);
  assign md_ready_o = r_ready_en && (r_count != 2'd2);
  assign we_o       = r_we;
  assign rd_o       = r_rd;
  assign wd_o       = r_wd;

  assign w_mem_wr = mem_valid_i && (mem_wb_sel_i != WB_SEL_NONE) &&
                    (mem_rd_i != 5'd0) && !stall_o;

`ifdef WB_LOAD_MISALIGN_EN
  logic w_ld_mis;
  logic r_misalign;

  assign w_ld_mis = mem_valid_i && !stall_o && (mem_wb_sel_i == WB_SEL_LOAD) &&
                    ld_misaligned(mem_funct3_i, mem_addr_lo_i);
  assign w_pw          = w_mem_wr && !w_ld_mis;
  assign ld_misalign_o = r_misalign;

  // Flag pulse lines up with the suppressed write slot
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_misalign <= 1'b0;
    else        r_misalign <= w_ld_mis;
  end
`else
  assign w_pw = w_mem_wr;
`endif

  // x0 results are accepted from the mul/div unit but never stored
  assign w_push = md_valid_i && md_ready_o && (md_rd_i != 5'd0);
  assign w_pop  = !w_pw && (r_count != 2'd0);

  // Pipeline write-data source select
  always_comb begin
    w_pipe_wd = mem_alu_res_i;
    case (mem_wb_sel_i)
      WB_SEL_LOAD: w_pipe_wd = w_ld_val;
      WB_SEL_PC4:  w_pipe_wd = mem_pc4_i;
      default:     w_pipe_wd = mem_alu_res_i;
    endcase
  end

  // Register-file write port: pipeline first, then buffer head
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we <= 1'b0;
      r_rd <= 5'd0;
      r_wd <= '0;
    end else if (w_pw) begin
      r_we <= 1'b1;
      r_rd <= mem_rd_i;
      r_wd <= w_pipe_wd;
    end else if (w_pop) begin
      r_we <= 1'b1;
      r_rd <= r_buf_rd[r_head];
      r_wd <= r_buf_data[r_head];
    end else begin
      r_we <= 1'b0;
    end
  end

  // Mul/div result FIFO; a push lands before it can be popped
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_count    <= 2'd0;
      r_ready_en <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_buf_rd[i]   <= 5'd0;
        r_buf_data[i] <= '0;
      end
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) begin
        r_buf_rd[r_tail]   <= md_rd_i;
        r_buf_data[r_tail] <= md_result_i;
        r_tail             <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation counter: counts cycles the head is bypassed by the pipeline
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_starve <= 4'd0;
    end else if (w_pop) begin
      r_starve <= 4'd0;
    end else if (w_pw && (r_count != 2'd0) && (r_starve != c_starve_max)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

endmodule
`default_nettype wire
